or1k_bus_arbiter: RTL and testbench
===================================

Name: or1k_bus_arbiter

Overview:
Parametrised N-channel arbiter that merges OR1K-style requester buses (ibus, dbus, debug/DMA masters) onto one shared memory bus using the req/ack/err/burst handshake. It supports fixed-priority or round-robin arbitration, bounded burst lock, per-transaction timeout with error return, and a grant vector for monitors. It sits between the CPU/DU bus ports and the SoC memory bus.

Parameters:
NUM_CH, 2, number of requester channels (1..8); index 0 highest priority in FIXED mode
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width; byte-select width BSEL_W = DATA_WIDTH/8
BURST_LEN, 4, maximum beats per locked burst (power of two, >=2)
ARB_MODE, "ROUND_ROBIN", "ROUND_ROBIN" or "FIXED"
TIMEOUT_CYCLES, 255, cycles without ack before forced error; 0 disables timeout

Ports:
clk  in  1  clock
rst  in  1  reset
ch_req_i  in  NUM_CH  per-channel request
ch_we_i  in  NUM_CH  per-channel write enable
ch_burst_i  in  NUM_CH  per-channel burst-continue indicator
ch_adr_i  in  NUM_CH*ADDR_WIDTH  per-channel address, channel k in slice k
ch_dat_i  in  NUM_CH*DATA_WIDTH  per-channel write data
ch_bsel_i  in  NUM_CH*BSEL_W  per-channel byte selects
ch_ack_o  out  NUM_CH  per-channel ack (one-hot or zero)
ch_err_o  out  NUM_CH  per-channel error (one-hot or zero)
ch_dat_o  out  DATA_WIDTH  read data broadcast to all channels; valid with ch_ack_o
mem_req_o  out  1  shared bus request
mem_we_o  out  1  shared bus write enable
mem_burst_o  out  1  shared bus burst indicator
mem_adr_o  out  ADDR_WIDTH  shared bus address
mem_dat_o  out  DATA_WIDTH  shared bus write data
mem_bsel_o  out  BSEL_W  shared bus byte selects
mem_ack_i  in  1  shared bus ack
mem_err_i  in  1  shared bus error
mem_dat_i  in  DATA_WIDTH  shared bus read data
grant_o  out  NUM_CH  registered one-hot owner vector
busy_o  out  1  high while state is ACTIVE

Behaviour:
- Interface: single clock clk; rst is synchronous, active-high.
- Reset: state IDLE, grant_o=0, rr pointer=0, beat_cnt=0, timeout counter=0. All outputs are 0 on the cycle after rst is sampled high. Reset mid-transaction aborts it with no ack or err returned.
- FSM IDLE:
  - If any ch_req_i is high, register the winner into grant_o and go to ACTIVE on the next edge.
  - Latency: a request sampled at edge N gives mem_req_o high from cycle N+1.
- Arbitration:
  - FIXED: lowest asserted index wins.
  - ROUND_ROBIN: search starts at (last_owner+1) mod NUM_CH; the pointer updates when the transaction ends.
- FSM ACTIVE, owner o:
  - mem_req_o = ch_req_i[o].
  - mem_adr/dat/bsel/we are combinational muxes of channel o.
  - mem_burst_o = ch_burst_i[o] & (beat_cnt != BURST_LEN-1).
  - ch_ack_o[o] = mem_ack_i & ~mem_err_i, combinational, same cycle.
  - ch_dat_o = mem_dat_i, always.
- Beat end: on each ack, beat_cnt increments. The transaction ends on an ack where mem_burst_o is low, i.e. the owner's burst is low or beat_cnt == BURST_LEN-1 (a forced lock release; the owner re-arbitrates for the remaining beats).
- Error:
  - mem_err_i in ACTIVE drives ch_err_o[o]=1 that cycle and ends the transaction.
  - If mem_ack_i and mem_err_i are high together, err wins and the ack is suppressed.
- Timeout:
  - The counter increments each ACTIVE cycle without ack/err and clears on ack.
  - When it reaches TIMEOUT_CYCLES, the arbiter pulses ch_err_o[o]=1 for one cycle (mem_req_o low that cycle) and ends the transaction.
  - Disabled when TIMEOUT_CYCLES=0.
- Abort: if ch_req_i[o] drops in ACTIVE before an ending ack, the transaction ends with no ack or err.
- End of transaction:
  - Next state is IDLE, grant_o clears and beat_cnt clears.
  - There is always one IDLE cycle between transactions.
  - Requests from non-owners are held and never acked while another channel owns the bus.
- Non-owner ch_ack_o/ch_err_o are always 0. grant_o is one-hot in ACTIVE and zero in IDLE.
- Counter widths: beat_cnt is $clog2(BURST_LEN) bits. The timeout counter is $clog2(TIMEOUT_CYCLES+1) bits and saturates; it does not wrap.

Test Plan:
- Single read: ch1 requests adr 0x0000_0100, mem acks at cycle 3 with data 0xDEAD_BEEF. Required: mem_req_o rises 1 cycle after request; ch_ack_o=2'b10 and ch_dat_o=0xDEAD_BEEF in the ack cycle; grant_o returns to 0 next cycle.
- Round-robin fairness: ch0 and ch1 request continuously with single beats. Required: grants alternate 01,10,01,10 with one IDLE cycle between. Under FIXED, ch0 wins every time.
- Burst lock: ch0 holds burst for 6 beats with BURST_LEN=4. Required: mem_burst_o low on the 4th beat, the transaction ends after 4 acks, and ch1 (pending) is granted before ch0's remaining beats.
- Error priority: mem_ack_i and mem_err_i high together in beat 2 of a burst. Required: ch_err_o[owner]=1, no ack that cycle, state returns to IDLE.
- Timeout: TIMEOUT_CYCLES=8, no ack. Required: ch_err_o[owner] pulses exactly 8 cycles after mem_req_o rises, then the arbiter is IDLE and re-grants.
- Reset mid-burst: assert rst during beat 2. Required: all outputs 0 next cycle, no ack/err, and after release ch0 wins first under ROUND_ROBIN (pointer reset).

Source files
------------

// File: rtl/or1k_bus_arbiter.sv
// Merges NUM_CH req/ack requesters onto one memory bus with fixed or round-robin priority, burst lock and timeout.
// Grant one edge after request, beats pass through combinationally; non-owners are held, never acked.
module or1k_bus_arbiter #(
    parameter int    NUM_CH         = 2,
    parameter int    ADDR_WIDTH     = 32,
    parameter int    DATA_WIDTH     = 32,
    parameter int    BURST_LEN      = 4,
    parameter string ARB_MODE       = "ROUND_ROBIN",
    parameter int    TIMEOUT_CYCLES = 255,
    localparam int   BSEL_W         = DATA_WIDTH / 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH-1:0]            ch_req_i,
    input  logic [NUM_CH-1:0]            ch_we_i,
    input  logic [NUM_CH-1:0]            ch_burst_i,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] ch_adr_i,
    input  logic [NUM_CH*DATA_WIDTH-1:0] ch_dat_i,
    input  logic [NUM_CH*BSEL_W-1:0]     ch_bsel_i,
    output logic [NUM_CH-1:0]            ch_ack_o,
    output logic [NUM_CH-1:0]            ch_err_o,
    output logic [DATA_WIDTH-1:0]        ch_dat_o,
    output logic                         mem_req_o,
    output logic                         mem_we_o,
    output logic                         mem_burst_o,
    output logic [ADDR_WIDTH-1:0]        mem_adr_o,
    output logic [DATA_WIDTH-1:0]        mem_dat_o,
    output logic [BSEL_W-1:0]            mem_bsel_o,
    input  logic                         mem_ack_i,
    input  logic                         mem_err_i,
    input  logic [DATA_WIDTH-1:0]        mem_dat_i,
    output logic [NUM_CH-1:0]            grant_o,
    output logic                         busy_o
);

    localparam int OW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int BW = $clog2(BURST_LEN);
    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [BW-1:0] BEAT_LAST = BW'(BURST_LEN - 1);
    localparam logic [TW-1:0] TO_MAX    = TW'(TIMEOUT_CYCLES);
    localparam logic [OW-1:0] OWN_LAST  = OW'(NUM_CH - 1);
    localparam bit IS_FIXED = (ARB_MODE == "FIXED");
    localparam bit TO_EN    = (TIMEOUT_CYCLES != 0);

    typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [NUM_CH-1:0]   r_grant;
    logic [OW-1:0]       r_owner;
    logic [OW-1:0]       r_rr_ptr;
    logic [BW-1:0]       r_beat_cnt;
    logic [TW-1:0]       r_to_cnt;

    logic                w_win_vld;
    logic [OW-1:0]       w_win_idx;
    logic [NUM_CH-1:0]   w_win_oh;
    int                  w_k;

    logic                w_own_req;
    logic                w_own_we;
    logic                w_own_burst;
    logic [ADDR_WIDTH-1:0] w_own_adr;
    logic [DATA_WIDTH-1:0] w_own_dat;
    logic [BSEL_W-1:0]   w_own_bsel;

    logic                w_active;
    logic                w_timeout;
    logic                w_abort;
    logic                w_err_evt;
    logic                w_ack_evt;
    logic                w_end;

    // Round-robin search starts at r_rr_ptr, which already holds last_owner+1.
    always_comb begin
        w_win_vld = 1'b0;
        w_win_idx = '0;
        w_win_oh  = '0;
        w_k       = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_k = IS_FIXED ? i : ((int'(r_rr_ptr) + i) % NUM_CH);
            if (!w_win_vld && ch_req_i[w_k]) begin
                w_win_vld     = 1'b1;
                w_win_idx     = OW'(w_k);
                w_win_oh[w_k] = 1'b1;
            end
        end
    end

    // Grant is zero in IDLE, so every owner-muxed signal reads zero there.
    always_comb begin
        w_own_req   = 1'b0;
        w_own_we    = 1'b0;
        w_own_burst = 1'b0;
        w_own_adr   = '0;
        w_own_dat   = '0;
        w_own_bsel  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (r_grant[i]) begin
                w_own_req   = ch_req_i[i];
                w_own_we    = ch_we_i[i];
                w_own_burst = ch_burst_i[i];
                w_own_adr   = ch_adr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_own_dat   = ch_dat_i[i*DATA_WIDTH +: DATA_WIDTH];
                w_own_bsel  = ch_bsel_i[i*BSEL_W +: BSEL_W];
            end
        end
    end

    assign w_active  = (r_state == ST_ACTIVE);
    assign w_abort   = w_active && !w_own_req;
    assign w_timeout = TO_EN && w_active && (r_to_cnt == TO_MAX);
    assign w_err_evt = w_active && !w_abort && (w_timeout || mem_err_i);
    assign w_ack_evt = w_active && !w_abort && !w_timeout && mem_ack_i && !mem_err_i;
    assign w_end     = w_abort || w_err_evt || (w_ack_evt && !mem_burst_o);

    assign mem_req_o   = w_own_req && !w_timeout;
    assign mem_we_o    = w_own_we;
    assign mem_burst_o = w_own_burst && (r_beat_cnt != BEAT_LAST);
    assign mem_adr_o   = w_own_adr;
    assign mem_dat_o   = w_own_dat;
    assign mem_bsel_o  = w_own_bsel;
    assign ch_ack_o    = w_ack_evt ? r_grant : '0;
    assign ch_err_o    = w_err_evt ? r_grant : '0;
    assign ch_dat_o    = mem_dat_i;
    assign grant_o     = r_grant;
    assign busy_o      = w_active;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_win_vld) w_state_nxt = ST_ACTIVE;
            ST_ACTIVE: if (w_end)     w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_grant    <= '0;
            r_owner    <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
            r_to_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (!w_active) begin
                r_beat_cnt <= '0;
                r_to_cnt   <= '0;
                if (w_win_vld) begin
                    r_grant <= w_win_oh;
                    r_owner <= w_win_idx;
                end
            end else if (w_end) begin
                r_grant    <= '0;
                r_beat_cnt <= '0;
                r_to_cnt   <= '0;
                r_rr_ptr   <= (r_owner == OWN_LAST) ? '0 : r_owner + OW'(1);
            end else if (w_ack_evt) begin
                r_beat_cnt <= r_beat_cnt + BW'(1);
                r_to_cnt   <= '0;
            end else if (r_to_cnt != TO_MAX) begin
                r_to_cnt <= r_to_cnt + TW'(1);
            end
        end
    end

endmodule

// File: tb/tb_or1k_bus_arbiter.sv
// Directed stimulus pushes expected responses/grants; a negedge monitor pops and compares them.
module tb_or1k_bus_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  ch_req, ch_we, ch_burst;
    logic [63:0] ch_adr, ch_dat;
    logic [7:0]  ch_bsel;
    logic        mem_ack, mem_err;
    logic [31:0] mem_dat;

    logic [1:0]  ch_ack_o, ch_err_o, grant_o;
    logic [31:0] ch_dat_o, mem_adr_o, mem_dat_o;
    logic        mem_req_o, mem_we_o, mem_burst_o, busy_o;
    logic [3:0]  mem_bsel_o;

    logic [1:0]  f_ack_o, f_err_o, f_grant;
    logic [31:0] f_dat_o, f_adr_o, f_mdat_o;
    logic        f_req_o, f_we_o, f_burst_o, f_busy;
    logic [3:0]  f_bsel_o;
    logic        f_err_in;

    typedef struct {
        logic [1:0]  ack;
        logic [1:0]  err;
        logic [31:0] dat;
        logic        burst;
        logic        req;
        logic [31:0] adr;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [1:0] g;
        int         cyc;
    } gexp_t;

    exp_t  ev_q[$];
    gexp_t gr_q[$];
    exp_t  mon_e;
    gexp_t mon_g;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   fix_cnt = 0;
    int   c;
    logic fix_win = 1'b0;
    logic [1:0] prev_grant = '0;
    logic [1:0] prev_f_grant = '0;

    or1k_bus_arbiter #(.NUM_CH(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .BURST_LEN(4),
                       .ARB_MODE("ROUND_ROBIN"), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .ch_req_i(ch_req), .ch_we_i(ch_we), .ch_burst_i(ch_burst),
        .ch_adr_i(ch_adr), .ch_dat_i(ch_dat), .ch_bsel_i(ch_bsel),
        .ch_ack_o(ch_ack_o), .ch_err_o(ch_err_o), .ch_dat_o(ch_dat_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_burst_o(mem_burst_o),
        .mem_adr_o(mem_adr_o), .mem_dat_o(mem_dat_o), .mem_bsel_o(mem_bsel_o),
        .mem_ack_i(mem_ack), .mem_err_i(mem_err), .mem_dat_i(mem_dat),
        .grant_o(grant_o), .busy_o(busy_o)
    );

    // Second instance in FIXED mode, with a memory that acks every request at once.
    assign f_err_in = 1'b0;
    or1k_bus_arbiter #(.NUM_CH(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .BURST_LEN(4),
                       .ARB_MODE("FIXED"), .TIMEOUT_CYCLES(8)) dut_fix (
        .clk(clk), .rst(rst),
        .ch_req_i(ch_req), .ch_we_i(ch_we), .ch_burst_i(ch_burst),
        .ch_adr_i(ch_adr), .ch_dat_i(ch_dat), .ch_bsel_i(ch_bsel),
        .ch_ack_o(f_ack_o), .ch_err_o(f_err_o), .ch_dat_o(f_dat_o),
        .mem_req_o(f_req_o), .mem_we_o(f_we_o), .mem_burst_o(f_burst_o),
        .mem_adr_o(f_adr_o), .mem_dat_o(f_mdat_o), .mem_bsel_o(f_bsel_o),
        .mem_ack_i(f_req_o), .mem_err_i(f_err_in), .mem_dat_i(mem_dat),
        .grant_o(f_grant), .busy_o(f_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_ev(input logic [1:0] ack, input logic [1:0] err, input logic [31:0] dat,
                           input logic burst, input logic req, input logic [31:0] adr, input int at);
        exp_t e;
        e.ack = ack; e.err = err; e.dat = dat; e.burst = burst; e.req = req; e.adr = adr; e.cyc = at;
        ev_q.push_back(e);
    endtask

    task automatic push_gr(input logic [1:0] g, input int at);
        gexp_t e;
        e.g = g; e.cyc = at;
        gr_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if ((ch_ack_o | ch_err_o) != 2'b00) begin
            if (ev_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: ack=%b err=%b at cycle %0d, none expected", ch_ack_o, ch_err_o, cyc);
            end else begin
                mon_e = ev_q.pop_front();
                chk("resp_cycle", 64'(cyc), 64'(mon_e.cyc));
                chk("ch_ack", 64'(ch_ack_o), 64'(mon_e.ack));
                chk("ch_err", 64'(ch_err_o), 64'(mon_e.err));
                if (mon_e.ack != 2'b00) chk("ch_dat", 64'(ch_dat_o), 64'(mon_e.dat));
                chk("mem_burst", 64'(mem_burst_o), 64'(mon_e.burst));
                chk("mem_req", 64'(mem_req_o), 64'(mon_e.req));
                chk("mem_adr", 64'(mem_adr_o), 64'(mon_e.adr));
            end
        end
        if (grant_o != 2'b00 && prev_grant == 2'b00) begin
            if (gr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_grant: grant=%b at cycle %0d, none expected", grant_o, cyc);
            end else begin
                mon_g = gr_q.pop_front();
                chk("grant_cycle", 64'(cyc), 64'(mon_g.cyc));
                chk("grant", 64'(grant_o), 64'(mon_g.g));
                chk("grant_busy", 64'(busy_o), 64'd1);
            end
        end
        if (fix_win && f_grant != 2'b00 && prev_f_grant == 2'b00) begin
            chk("fixed_grant", 64'(f_grant), 64'h1);
            fix_cnt++;
        end
        prev_grant   = grant_o;
        prev_f_grant = f_grant;
    end

    initial begin
        rst = 1'b1; ch_req = '0; ch_we = '0; ch_burst = '0;
        ch_adr = '0; ch_dat = 64'h2222_2222_1111_1111; ch_bsel = 8'hFF;
        mem_ack = 1'b0; mem_err = 1'b0; mem_dat = '0;
        tick(2);
        chk("rst_grant", 64'(grant_o), 64'h0);
        chk("rst_busy", 64'(busy_o), 64'h0);
        chk("rst_mem_req", 64'(mem_req_o), 64'h0);
        rst = 1'b0;
        tick(2);

        // Single read from ch1, acked on the third cycle.
        c = cyc;
        ch_req = 2'b10; ch_adr[63:32] = 32'h0000_0100;
        push_gr(2'b10, c + 1);
        tick(3);
        mem_ack = 1'b1; mem_dat = 32'hDEAD_BEEF;
        push_ev(2'b10, 2'b00, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h100, c + 3);
        tick();
        mem_ack = 1'b0; ch_req = 2'b00;
        chk("t1_grant_cleared", 64'(grant_o), 64'h0);
        tick(3);

        // Round-robin fairness; the FIXED instance must keep picking ch0.
        c = cyc;
        fix_win = 1'b1;
        ch_req = 2'b11; ch_adr = {32'h0000_1100, 32'h0000_1000};
        for (int t = 0; t < 4; t++) push_gr((t % 2 == 0) ? 2'b01 : 2'b10, c + 1 + 2*t);
        tick();
        for (int t = 0; t < 4; t++) begin
            mem_ack = 1'b1; mem_dat = 32'hA000_0000 + 32'(t);
            push_ev((t % 2 == 0) ? 2'b01 : 2'b10, 2'b00, mem_dat, 1'b0, 1'b1,
                    (t % 2 == 0) ? 32'h1000 : 32'h1100, c + 1 + 2*t);
            tick();
            mem_ack = 1'b0;
            if (t == 3) ch_req = 2'b00;
            tick();
        end
        fix_win = 1'b0;
        chk("fixed_grant_count", 64'(fix_cnt), 64'd4);
        tick(3);

        // Burst lock: ch0 wants 6 beats, lock releases after 4 and ch1 gets in.
        c = cyc;
        ch_req = 2'b11; ch_burst = 2'b01; ch_adr = {32'h0000_0300, 32'h0000_0200};
        push_gr(2'b01, c + 1); push_gr(2'b10, c + 6); push_gr(2'b01, c + 8);
        tick();
        for (int b = 0; b < 4; b++) begin
            mem_ack = 1'b1; mem_dat = 32'hB0 + 32'(b);
            push_ev(2'b01, 2'b00, mem_dat, (b != 3), 1'b1, 32'h200, c + 1 + b);
            tick();
        end
        mem_ack = 1'b0;
        tick();
        mem_ack = 1'b1; mem_dat = 32'hC1;
        push_ev(2'b10, 2'b00, 32'hC1, 1'b0, 1'b1, 32'h300, c + 6);
        tick();
        mem_ack = 1'b0; ch_req = 2'b01;
        tick();
        mem_ack = 1'b1; mem_dat = 32'hB4;
        push_ev(2'b01, 2'b00, 32'hB4, 1'b1, 1'b1, 32'h200, c + 8);
        tick();
        ch_burst = 2'b00; mem_dat = 32'hB5;
        push_ev(2'b01, 2'b00, 32'hB5, 1'b0, 1'b1, 32'h200, c + 9);
        tick();
        mem_ack = 1'b0; ch_req = 2'b00;
        tick(3);

        // Error beats ack in beat 2 of a ch1 burst.
        c = cyc;
        ch_req = 2'b10; ch_burst = 2'b10; ch_adr[63:32] = 32'h0000_0400;
        push_gr(2'b10, c + 1);
        tick();
        mem_ack = 1'b1; mem_dat = 32'hD1;
        push_ev(2'b10, 2'b00, 32'hD1, 1'b1, 1'b1, 32'h400, c + 1);
        tick();
        mem_err = 1'b1;
        push_ev(2'b00, 2'b10, 32'h0, 1'b1, 1'b1, 32'h400, c + 2);
        tick();
        mem_ack = 1'b0; mem_err = 1'b0; ch_req = 2'b00; ch_burst = 2'b00;
        chk("t4_busy_after_err", 64'(busy_o), 64'h0);
        tick(3);

        // Timeout: no ack for 8 cycles, then re-grant and complete.
        c = cyc;
        ch_req = 2'b01; ch_adr[31:0] = 32'h0000_0500;
        push_gr(2'b01, c + 1);
        push_ev(2'b00, 2'b01, 32'h0, 1'b0, 1'b0, 32'h500, c + 9);
        push_gr(2'b01, c + 11);
        tick(10);
        chk("t5_idle_after_timeout", 64'(busy_o), 64'h0);
        tick();
        mem_ack = 1'b1; mem_dat = 32'hE1;
        push_ev(2'b01, 2'b00, 32'hE1, 1'b0, 1'b1, 32'h500, c + 11);
        tick();
        mem_ack = 1'b0; ch_req = 2'b00;
        tick(3);

        // Reset during beat 2 of a ch0 burst; ch0 must win first afterwards.
        c = cyc;
        ch_req = 2'b01; ch_burst = 2'b01; ch_adr[31:0] = 32'h0000_0600;
        push_gr(2'b01, c + 1);
        tick();
        mem_ack = 1'b1; mem_dat = 32'hF1;
        push_ev(2'b01, 2'b00, 32'hF1, 1'b1, 1'b1, 32'h600, c + 1);
        tick();
        mem_ack = 1'b0; mem_dat = '0; rst = 1'b1;
        tick();
        chk("t6_rst_mem_req", 64'(mem_req_o), 64'h0);
        chk("t6_rst_mem_burst", 64'(mem_burst_o), 64'h0);
        chk("t6_rst_mem_adr", 64'(mem_adr_o), 64'h0);
        chk("t6_rst_grant", 64'(grant_o), 64'h0);
        chk("t6_rst_busy", 64'(busy_o), 64'h0);
        chk("t6_rst_ack_err", 64'({ch_ack_o, ch_err_o}), 64'h0);
        ch_req = 2'b11; ch_burst = 2'b00; ch_adr[63:32] = 32'h0000_0700;
        tick();
        rst = 1'b0;
        push_gr(2'b01, c + 5);
        tick();
        mem_ack = 1'b1; mem_dat = 32'hF2;
        push_ev(2'b01, 2'b00, 32'hF2, 1'b0, 1'b1, 32'h600, c + 5);
        tick();
        mem_ack = 1'b0; ch_req = 2'b00;
        tick(5);

        chk("resp_queue_drained", 64'(ev_q.size()), 64'd0);
        chk("grant_queue_drained", 64'(gr_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
